// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over valid/ready
// and shifts it onto SO one bit per enabled CP edge, with FRAME/DONE framing.
module piso_shift_tx #(
   parameter int WIDTH      = 4,
   parameter bit LSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             CP,
   input  logic             CD,
   input  logic [WIDTH-1:0] D,
   input  logic             LOAD_VALID,
   output logic             LOAD_READY,
   input  logic             EN,
   output logic             SO,
   output logic             SON,
   output logic             FRAME,
   output logic             DONE
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             so_q, so_d;
   logic             last_bit, xfer;

   function automatic logic head(input logic [WIDTH-1:0] w);
      return LSB_FIRST ? w[0] : w[WIDTH-1];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return LSB_FIRST ? {1'b0, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b0};
   endfunction

   // so_q holds the bit on the wire; sh_q holds only the bits still to come.
   always_comb begin
      state_d    = state_q;
      sh_d       = sh_q;
      cnt_d      = cnt_q;
      so_d       = so_q;
      last_bit   = (state_q == SHIFT) && (cnt_q == LAST);
      LOAD_READY = (state_q == IDLE) || (last_bit && EN);
      DONE       = last_bit && EN;
      xfer       = LOAD_VALID && LOAD_READY;
      if (xfer) begin
         state_d = SHIFT;
         so_d    = head(D);
         sh_d    = advance(D);
         cnt_d   = '0;
      end else if (state_q == SHIFT && EN) begin
         if (last_bit) begin
            state_d = IDLE;
            so_d    = IDLE_LEVEL;
            sh_d    = '0;
            cnt_d   = '0;
         end else begin
            so_d  = head(sh_q);
            sh_d  = advance(sh_q);
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CP or negedge CD) begin
      if (!CD) begin
         state_q <= IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
         so_q    <= IDLE_LEVEL;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         so_q    <= so_d;
      end
   end

   assign SO    = so_q;
   assign SON   = ~so_q;
   assign FRAME = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_shift_tx.sv
// Scoreboarded bench for piso_shift_tx: an LSB-first and an MSB-first instance
// share stimulus; a word queue model predicts every cycle's outputs.
module tb_piso_shift_tx;
   localparam int W = 4;

   logic         CP = 1'b0;
   logic         CD = 1'b0;
   logic [W-1:0] D = '0;
   logic         LOAD_VALID = 1'b0;
   logic         EN = 1'b1;
   logic [1:0]   so, son, frame, done, rdy;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [W-1:0] w;
      int           idx;
   } ent_t;
   ent_t q[$];

   piso_shift_tx #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_lsb (
      .CP(CP), .CD(CD), .D(D), .LOAD_VALID(LOAD_VALID), .LOAD_READY(rdy[0]),
      .EN(EN), .SO(so[0]), .SON(son[0]), .FRAME(frame[0]), .DONE(done[0]));

   piso_shift_tx #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_msb (
      .CP(CP), .CD(CD), .D(D), .LOAD_VALID(LOAD_VALID), .LOAD_READY(rdy[1]),
      .EN(EN), .SO(so[1]), .SON(son[1]), .FRAME(frame[1]), .DONE(done[1]));

   always #5 CP = ~CP;

   task automatic chk(input string name, input int k, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[%0s] t=%0t got %b expected %b", name, k ? "msb" : "lsb", $time, act, exp);
      end
   endtask

   task automatic chk_reset_vals();
      for (int k = 0; k < 2; k++) begin
         chk("rst_so", k, so[k], 1'b0);
         chk("rst_son", k, son[k], 1'b1);
         chk("rst_frame", k, frame[k], 1'b0);
         chk("rst_done", k, done[k], 1'b0);
         chk("rst_ready", k, rdy[k], 1'b1);
      end
   endtask

   // Monitor: compares against the queue head each cycle, then applies the
   // model's view of the coming edge (bit consumed, word accepted).
   always @(negedge CP) begin
      logic exp_rdy;
      if (!CD) begin
         q.delete();
         chk_reset_vals();
      end else begin
         exp_rdy = 1'b1;
         for (int k = 0; k < 2; k++) begin
            if (q.size() > 0) begin
               logic eb, last;
               eb   = (k == 0) ? q[0].w[q[0].idx] : q[0].w[W-1-q[0].idx];
               last = (q[0].idx == W - 1);
               chk("so", k, so[k], eb);
               chk("frame", k, frame[k], 1'b1);
               chk("done", k, done[k], last && EN);
               chk("ready", k, rdy[k], last && EN);
               exp_rdy = last && EN;
            end else begin
               chk("idle_so", k, so[k], 1'b0);
               chk("idle_frame", k, frame[k], 1'b0);
               chk("idle_done", k, done[k], 1'b0);
               chk("idle_ready", k, rdy[k], 1'b1);
            end
            chk("son", k, son[k], ~so[k]);
         end
         if (q.size() > 0 && EN) void'(q.pop_front());
         if (LOAD_VALID && exp_rdy)
            for (int i = 0; i < W; i++) q.push_back('{w: D, idx: i});
      end
   end

   task automatic cyc(input logic lv, input logic [W-1:0] d, input logic en);
      @(posedge CP);
      #1;
      LOAD_VALID = lv;
      D          = d;
      EN         = en;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, W'($urandom), 1'b1);
   endtask

   // CD dropped between edges; outputs must clear before any CP edge.
   task automatic async_reset();
      @(posedge CP);
      #2 CD = 1'b0;
      #1 chk_reset_vals();
      @(posedge CP);
      #1 CD = 1'b1;
   endtask

   initial begin
      CD = 1'b0;
      repeat (2) @(posedge CP);
      #1 CD = 1'b1;
      idle(3);
      async_reset();
      idle(1);

      cyc(1'b1, 4'b1011, 1'b1);
      idle(5);
      cyc(1'b1, 4'b1000, 1'b1);
      idle(5);

      // back-to-back: second word offered during the first word's last bit
      cyc(1'b1, 4'b0001, 1'b1);
      idle(3);
      cyc(1'b1, 4'b1110, 1'b1);
      idle(5);

      // stall on bit 2, then on the last bit with a word waiting
      cyc(1'b1, 4'b0110, 1'b1);
      cyc(1'b0, 4'b0000, 1'b1);
      cyc(1'b0, 4'b0000, 1'b0);
      cyc(1'b0, 4'b0000, 1'b0);
      cyc(1'b0, 4'b0000, 1'b1);
      cyc(1'b0, 4'b0000, 1'b1);
      cyc(1'b1, 4'b1001, 1'b0);
      cyc(1'b1, 4'b1001, 1'b0);
      cyc(1'b1, 4'b1001, 1'b1);
      cyc(1'b0, 4'b0000, 1'b1);
      idle(5);

      // reset mid-word, then a clean word
      cyc(1'b1, 4'b1111, 1'b1);
      cyc(1'b0, 4'b0000, 1'b1);
      async_reset();
      cyc(1'b1, 4'b0101, 1'b1);
      idle(6);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 79) == 0) async_reset();
         else cyc(1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 9) < 7);
      end
      idle(6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
